vreg_issue_scoreboard: RTL
==========================

Name: vreg_issue_scoreboard

Overview:
- Parametrised successor to the control unit's combinational register-read select decoder.
- Decodes the opcode into a source-read select and destination-write and load flags, then tracks in-flight register writes.
- Stalls issue on RAW/WAW hazards against fixed-latency ALU results and variable-latency vector loads.
- Sits in CtrlUnit between fetch/decode and the register-file read stage; drives the register-file mux select and the pipeline stall.

Parameters:
- NREG, 16, number of architectural vector registers.
- OP_W, 5, opcode width.
- WB_LAT, 3, cycles from issue to register write for non-load ops (range 1..15).
- MAX_LD, 4, maximum outstanding loads.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  decoded instruction present.
- opcode  in  OP_W  instruction opcode.
- rd  in  $clog2(NREG)  destination register.
- r2  in  $clog2(NREG)  source register 2.
- r3  in  $clog2(NREG)  source register 3.
- flush  in  1  pipeline flush; blocks issue this cycle.
- ld_done_valid  in  1  load data written back.
- ld_done_reg  in  $clog2(NREG)  register written by the completing load.
- issue_ready  out  1  instruction accepted this cycle (issue_valid and no hazard).
- stall  out  1  issue_valid and not issue_ready.
- rsel  out  2  source select: 00 both R2 and R3, 01 R2 only, 10 R3 only, 11 none.
- busy_vec  out  NREG  registered per-register busy (counter non-zero or load-pending).
- ld_count  out  $clog2(MAX_LD+1)  outstanding loads.

Behaviour:
Reset:
- On rst high at a clock edge: all WB counters = 0, all load-pending bits = 0, ld_count = 0.
- busy_vec is 0 the following cycle. issue_ready/stall are combinational and follow the cleared state.
- rst overrides every other input, including mid-flight loads; late ld_done for a cleared register is ignored.

Decode (combinational, package table):
- rsel:
  - 10001, 10011 -> 11.
  - 10101, 10111 -> 10.
  - 01001, 11011 -> 01.
  - all other opcodes -> 00.
- writes_rd = 0 for opcode[4:3] == 11 (stores/branches), else 1.
- is_load = 1 for 10101 and 10111.

Hazard (uses registered state only):
- hazard when any of the following holds:
  - rsel selects R2 and busy[r2];
  - rsel selects R3 and busy[r3];
  - writes_rd and busy[rd];
  - is_load and ld_count == MAX_LD;
  - flush.
- issue_ready = issue_valid & ~hazard.

On accept:
- Non-load with writes_rd: cnt[rd] <= WB_LAT.
- Load: ldp[rd] <= 1 and ld_count increments.
- Non-writing op: no state change.

Each cycle:
- Every non-zero cnt decrements by 1. A register is free the cycle after its count reaches 0.
- An instruction issued at cycle t with WB_LAT = 3 makes its rd free for readers at t+3.

ld_done_valid:
- If ldp[ld_done_reg] = 1: clear it and decrement ld_count.
- If ldp[ld_done_reg] = 0: ignore; no count change.

Simultaneous events:
- ld_done for X plus issue reading X in the same cycle -> stall this cycle, accept next.
- Load accept plus ld_done in the same cycle -> ld_count unchanged net, with both bit updates applied.
- Load accept while ld_count == MAX_LD is impossible (hazard).

flush:
- Does not clear counters or load bits; in-flight writes still land.

ld_count:
- Saturates by construction; never wraps.

Decomposition:
- Package vreg_issue_pkg holds:
  - rsel_e enum (BOTH = 2'b00, R2 = 2'b01, R3 = 2'b10, NONE = 2'b11);
  - opcode localparams;
  - decode function returning {rsel, writes_rd, is_load}.
- One sub-module, vreg_op_decode: the combinational decode. The scoreboard state stays in the top level.

Test Plan:
- Reset then opcode 01001, r2 = 5, issue_valid -> rsel = 01, issue_ready = 1, busy_vec = 0.
- ALU op 00000 rd = 3 issued at t0 (WB_LAT = 3); next op reads r2 = 3 -> stall at t1..t2, accepted at t3; busy_vec[3] = 1 for t1..t3.
- Load 10101 rd = 7 -> ldp[7] set; reader of r3 = 7 stalls indefinitely until ld_done_valid reg 7; accepted the cycle after; ld_count returns 1 -> 0.
- Issue 4 loads to rd = 1..4, then a 5th -> stall with ld_count = 4; ld_done reg 2 -> 5th accepted the next cycle, ld_count stays 4.
- Opcode 10001 (rsel = 11) with r2/r3 busy -> no stall. Store 11011 with busy rd and free r2 -> no stall (writes_rd = 0).
- Load outstanding on rd = 9 plus cnt[3] = 2, then rst -> busy_vec = 0 next cycle. Subsequent ld_done reg 9 is ignored; ld_count stays 0.

Source files
------------

// File: rtl/vreg_issue_scoreboard_pkg.sv
// Vector issue scoreboard shared types.
// Opcode constants, source-select enum and the decode table.
package vreg_issue_pkg;

  typedef enum logic [1:0] {
    BOTH = 2'b00,
    R2   = 2'b01,
    R3   = 2'b10,
    NONE = 2'b11
  } rsel_e;

  localparam logic [4:0] OP_NS_A = 5'b10001;
  localparam logic [4:0] OP_NS_B = 5'b10011;
  localparam logic [4:0] OP_LD_A = 5'b10101;
  localparam logic [4:0] OP_LD_B = 5'b10111;
  localparam logic [4:0] OP_R2_A = 5'b01001;
  localparam logic [4:0] OP_R2_B = 5'b11011;

  typedef struct packed {
    rsel_e rsel;
    logic  writes_rd;
    logic  is_load;
  } dec_t;

  function automatic dec_t op_decode(
    input logic [4:0] op
  );
    dec_t d;
    d.rsel      = BOTH;
    d.writes_rd = (op[4:3] != 2'b11);
    d.is_load   = 1'b0;
    case (op)
      OP_NS_A, OP_NS_B: d.rsel = NONE;
      OP_LD_A, OP_LD_B: begin
        d.rsel    = R3;
        d.is_load = 1'b1;
      end
      OP_R2_A, OP_R2_B: d.rsel = R2;
      default:          d.rsel = BOTH;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vreg_issue_scoreboard_if.sv
// Issue channel and load-writeback channel of the scoreboard.
// master: decode side driving instructions; slave: scoreboard.
interface vreg_issue_scoreboard_if #(
  parameter int NREG = 16,
  parameter int OP_W = 5
);
  localparam int RW = $clog2(NREG);

  logic            issue_valid;
  logic [OP_W-1:0] opcode;
  logic [RW-1:0]   rd;
  logic [RW-1:0]   r2;
  logic [RW-1:0]   r3;
  logic            flush;
  logic            ld_done_valid;
  logic [RW-1:0]   ld_done_reg;
  logic            issue_ready;
  logic            stall;
  logic [1:0]      rsel;

  modport master (
    output issue_valid, opcode, rd, r2, r3,
    output flush, ld_done_valid, ld_done_reg,
    input  issue_ready, stall, rsel
  );

  modport slave (
    input  issue_valid, opcode, rd, r2, r3,
    input  flush, ld_done_valid, ld_done_reg,
    output issue_ready, stall, rsel
  );

endinterface

// File: rtl/vreg_op_decode.sv
// Combinational opcode decode: source select, rd-write, load.
// Ports: opcode in, dec {rsel, writes_rd, is_load} out.
module vreg_op_decode
  import vreg_issue_pkg::*;
#(
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output dec_t            dec
);

  assign dec = op_decode(opcode[4:0]);

endmodule

// File: rtl/vreg_issue_scoreboard.sv
// Issue scoreboard: stalls on RAW/WAW against ALU and load writes.
// Ports: clk, rst, bus (issue/ld_done), busy_vec, ld_count.
module vreg_issue_scoreboard
  import vreg_issue_pkg::*;
#(
  parameter int NREG   = 16,
  parameter int OP_W   = 5,
  parameter int WB_LAT = 3,
  parameter int MAX_LD = 4,
  localparam int RW    = $clog2(NREG),
  localparam int LCW   = $clog2(MAX_LD + 1)
) (
  input  logic             clk,
  input  logic             rst,
  vreg_issue_scoreboard_if.slave bus,
  output logic [NREG-1:0]  busy_vec,
  output logic [LCW-1:0]   ld_count
);

  localparam logic [3:0]     WB_INIT = 4'(WB_LAT);
  localparam logic [LCW-1:0] LD_MAX  = LCW'(MAX_LD);

  logic [3:0]     r_cnt [NREG];
  logic [NREG-1:0] r_ldp;
  logic [LCW-1:0] r_ld_count;

  dec_t           w_dec;
  logic [NREG-1:0] w_hz;
  logic [NREG-1:0] w_ldp_nxt;
  logic           w_hazard;
  logic           w_acc;
  logic           w_ld_acc;
  logic           w_alu_acc;
  logic           w_ld_clr;

  vreg_op_decode #(
    .OP_W (OP_W)
  ) u_dec (
    .opcode (bus.opcode),
    .dec    (w_dec)
  );

  // A count of 1 means the write lands at this edge, so
  // a reader issued now already sees the new value.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      w_hz[i]     = (r_cnt[i] > 4'd1) | r_ldp[i];
      busy_vec[i] = (r_cnt[i] != 4'd0) | r_ldp[i];
    end
  end

  // rsel bit 1 clear -> R2 read; bit 0 clear -> R3 read.
  always_comb begin
    w_hazard = bus.flush;
    if (!w_dec.rsel[1] && w_hz[bus.r2])
      w_hazard = 1'b1;
    if (!w_dec.rsel[0] && w_hz[bus.r3])
      w_hazard = 1'b1;
    if (w_dec.writes_rd && w_hz[bus.rd])
      w_hazard = 1'b1;
    if (w_dec.is_load && r_ld_count == LD_MAX)
      w_hazard = 1'b1;
  end

  assign w_acc     = bus.issue_valid & ~w_hazard;
  assign w_ld_acc  = w_acc & w_dec.is_load;
  assign w_alu_acc = w_acc & w_dec.writes_rd
                   & ~w_dec.is_load;
  assign w_ld_clr  = bus.ld_done_valid
                   & r_ldp[bus.ld_done_reg];

  assign bus.issue_ready = w_acc;
  assign bus.stall       = bus.issue_valid & w_hazard;
  assign bus.rsel        = w_dec.rsel;
  assign ld_count        = r_ld_count;

  always_comb begin
    w_ldp_nxt = r_ldp;
    if (w_ld_clr)
      w_ldp_nxt[bus.ld_done_reg] = 1'b0;
    if (w_ld_acc)
      w_ldp_nxt[bus.rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        r_cnt[i] <= 4'd0;
      r_ldp      <= '0;
      r_ld_count <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_alu_acc && bus.rd == RW'(i))
          r_cnt[i] <= WB_INIT;
        else if (r_cnt[i] != 4'd0)
          r_cnt[i] <= r_cnt[i] - 4'd1;
      end
      r_ldp <= w_ldp_nxt;
      unique case ({w_ld_acc, w_ld_clr})
        2'b10:   r_ld_count <= r_ld_count + 1'b1;
        2'b01:   r_ld_count <= r_ld_count - 1'b1;
        default: r_ld_count <= r_ld_count;
      endcase
    end
  end

endmodule
